// File: rtl/mem_arb_pkg.sv
// Shared types for the memory arbiter: FSM states, owner encoding, latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Wide enough for RD_LAT-1 with RD_LAT up to 7.
    localparam int LAT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to whoever did not own last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,          // [0]=CPU, [1]=host
    input  owner_t     last_owner,
    output logic       pick_valid,
    output owner_t     pick_owner
);

    // Pick the winner among the current requesters.
    always_comb begin
        pick_valid = |req;
        pick_owner = OWN_CPU;
        if (req == 2'b11)
            pick_owner = (last_owner == OWN_CPU) ? OWN_HOST : OWN_CPU;
        else if (req[1])
            pick_owner = OWN_HOST;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the CPU and the host loader port.
// Accesses are serialised IDLE -> ISSUE (-> RWAIT for reads); all outputs are
// decoded from registered state, so no request input reaches an output combinationally.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
        $error("mem_arbiter: RD_LAT must be within 1..7");
    end

    // Access captured in IDLE and replayed to the memory in ISSUE.
    typedef struct packed {
        owner_t            owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    state_t           state, state_nxt;
    owner_t           last_owner;
    logic [LAT_W-1:0] lat_cnt;
    acc_t             acc;
    logic             pick_valid;
    owner_t           pick_owner;
    logic             issue, rd_done;

    rr_pick2 u_pick (
        .req        ({host_req, cpu_req}),
        .last_owner (last_owner),
        .pick_valid (pick_valid),
        .pick_owner (pick_owner)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture the winning access and advance the read-latency countdown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            last_owner <= OWN_HOST;
            lat_cnt    <= '0;
        end else begin
            if (state == IDLE && pick_valid) begin
                last_owner <= pick_owner;
                if (pick_owner == OWN_CPU)
                    acc <= '{owner: OWN_CPU, we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
                else
                    acc <= '{owner: OWN_HOST, we: host_we, addr: host_addr, wdata: host_wdata};
            end
            if (state == ISSUE && !acc.we)
                lat_cnt <= LAT_W'(RD_LAT - 1);
            else if (state == RWAIT && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        issue       = (state == ISSUE);
        rd_done     = (state == RWAIT) && (lat_cnt == '0);
        mem_en      = issue;
        mem_we      = issue && acc.we;
        mem_addr    = issue ? acc.addr  : '0;
        mem_wdata   = issue ? acc.wdata : '0;
        cpu_gnt     = issue && (acc.owner == OWN_CPU);
        host_gnt    = issue && (acc.owner == OWN_HOST);
        cpu_rvalid  = rd_done && (acc.owner == OWN_CPU);
        host_rvalid = rd_done && (acc.owner == OWN_HOST);
        cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
        host_rdata  = host_rvalid ? mem_rdata : '0;
        busy        = (state != IDLE);
        case (state)
            IDLE:    if (pick_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = acc.we ? IDLE : RWAIT;
            RWAIT:   if (lat_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with RD_LAT=1 and one with RD_LAT=3 share the same
// requester stimulus, each with its own behavioural memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
    logic [11:0] cpu_addr = '0, host_addr = '0;
    logic [15:0] cpu_wdata = '0, host_wdata = '0;

    logic        cpu_gnt1, cpu_rvalid1, host_gnt1, host_rvalid1, mem_en1, mem_we1, busy1;
    logic [15:0] cpu_rdata1, host_rdata1, mem_wdata1, rd1;
    logic [11:0] mem_addr1;
    logic        cpu_gnt3, cpu_rvalid3, host_gnt3, host_rvalid3, mem_en3, mem_we3, busy3;
    logic [15:0] cpu_rdata3, host_rdata3, mem_wdata3;
    logic [11:0] mem_addr3;
    logic [15:0] p3 [0:2];
    logic [15:0] mem1 [0:4095];
    logic [15:0] mem3 [0:4095];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt1), .cpu_rvalid(cpu_rvalid1), .cpu_rdata(cpu_rdata1),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt1), .host_rvalid(host_rvalid1), .host_rdata(host_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(rd1), .busy(busy1)
    );

    mem_arbiter #(.ADDR_W(12), .DATA_W(16), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt3), .cpu_rvalid(cpu_rvalid3), .cpu_rdata(cpu_rdata3),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt3), .host_rvalid(host_rvalid3), .host_rdata(host_rdata3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
        .mem_rdata(p3[2]), .busy(busy3)
    );

    // Memory with 1-cycle read latency; address 0x005 preloaded while in reset.
    always @(posedge clk) begin
        if (rst) mem1[12'h005] <= 16'h1ABC;
        else if (mem_en1 && mem_we1) mem1[mem_addr1] <= mem_wdata1;
        if (mem_en1) rd1 <= mem1[mem_addr1];
    end

    // Memory with 3-cycle read latency.
    always @(posedge clk) begin
        if (rst) mem3[12'h005] <= 16'h1ABC;
        else if (mem_en3 && mem_we3) mem3[mem_addr3] <= mem_wdata3;
        if (mem_en3) p3[0] <= mem3[mem_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        cpu_req  = 0;
        host_req = 0;
        repeat (n) step();
    endtask

    task automatic do_reset;
        cpu_req = 0; host_req = 0;
        rst = 1;
        step(); step();
        rst = 0;
        step();
    endtask

    initial begin
        int cc, hc, ng;
        int seq [0:3];

        // Reset state
        step();
        chk("rst_busy1", busy1, 0);
        chk("rst_out1", {cpu_gnt1, host_gnt1, cpu_rvalid1, host_rvalid1, mem_en1, mem_we1}, 0);
        chk("rst_addr1", {mem_addr1, mem_wdata1}, 0);
        chk("rst_out3", {busy3, cpu_gnt3, host_gnt3, mem_en3, mem_addr3}, 0);
        rst = 0;
        step();

        // CPU read of preloaded 0x005, RD_LAT=1
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        step();
        chk("t1_gnt", cpu_gnt1, 1);
        chk("t1_en", mem_en1, 1);
        chk("t1_addr", mem_addr1, 12'h005);
        chk("t1_hrv_c1", host_rvalid1, 0);
        cpu_req = 0;
        step();
        chk("t1_rvalid", cpu_rvalid1, 1);
        chk("t1_rdata", cpu_rdata1, 16'h1ABC);
        chk("t1_en_c2", mem_en1, 0);
        chk("t1_hrv_c2", {host_rvalid1, host_rdata1}, 0);
        step();
        chk("t1_rv_c3", {cpu_rvalid1, cpu_rdata1}, 0);
        chk("t1_busy_c3", busy1, 0);
        idle(6);

        // Host write 0x3F00 -> 0x0A0, then CPU reads it back
        host_req = 1; host_we = 1; host_addr = 12'h0A0; host_wdata = 16'h3F00;
        step();
        chk("t2_hgnt", host_gnt1, 1);
        chk("t2_we", mem_we1, 1);
        chk("t2_wdata", mem_wdata1, 16'h3F00);
        chk("t2_busy_c1", busy1, 1);
        host_req = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h0A0;
        step();
        chk("t2_busy_c2", busy1, 0);
        chk("t2_en_c2", mem_en1, 0);
        step();
        chk("t2_cgnt", cpu_gnt1, 1);
        chk("t2_busy_c3", busy1, 1);
        cpu_req = 0;
        step();
        chk("t2_rvalid", cpu_rvalid1, 1);
        chk("t2_rdata", cpu_rdata1, 16'h3F00);
        chk("t2_busy_c4", busy1, 1);
        step();
        chk("t2_busy_c5", busy1, 0);
        idle(6);

        // Simultaneous writes out of reset, two accesses each
        do_reset();
        cc = 0; hc = 0; ng = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 16'h0001;
        host_req = 1; host_we = 1; host_addr = 12'h020; host_wdata = 16'h0002;
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t3_excl", {cpu_gnt1 & host_gnt1}, 0);
            if (cpu_gnt1) begin
                if (ng < 4) seq[ng] = 0;
                ng++; cc++;
                if (cc == 2) cpu_req = 0;
            end
            if (host_gnt1) begin
                if (ng < 4) seq[ng] = 1;
                ng++; hc++;
                if (hc == 2) host_req = 0;
            end
        end
        chk("t3_count", ng, 4);
        chk("t3_ord0", seq[0], 0);
        chk("t3_ord1", seq[1], 1);
        chk("t3_ord2", seq[2], 0);
        chk("t3_ord3", seq[3], 1);
        idle(4);

        // RD_LAT=3: CPU read in cycle 1, host request from cycle 2
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        step();
        chk("t4_cgnt_c1", cpu_gnt3, 1);
        cpu_req = 0;
        step();
        host_req = 1; host_we = 1; host_addr = 12'h0B0; host_wdata = 16'h1234;
        chk("t4_en_c2", mem_en3, 0);
        chk("t4_rv_c2", cpu_rvalid3, 0);
        step();
        chk("t4_en_c3", mem_en3, 0);
        chk("t4_rv_c3", cpu_rvalid3, 0);
        chk("t4_hg_c3", host_gnt3, 0);
        step();
        chk("t4_en_c4", mem_en3, 0);
        chk("t4_rv_c4", cpu_rvalid3, 1);
        chk("t4_rd_c4", cpu_rdata3, 16'h1ABC);
        chk("t4_hrv_c4", host_rvalid3, 0);
        step();
        chk("t4_en_c5", mem_en3, 0);
        chk("t4_rv_c5", cpu_rvalid3, 0);
        chk("t4_hg_c5", host_gnt3, 0);
        step();
        chk("t4_hg_c6", host_gnt3, 1);
        host_req = 0;
        idle(6);

        // Reset during RWAIT (RD_LAT=3)
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h005;
        step();
        chk("t5_cgnt", cpu_gnt3, 1);
        cpu_req = 0;
        step();
        chk("t5_busy_pre", busy3, 1);
        rst = 1;
        #1;
        chk("t5_rst_ctl", {busy3, mem_en3, mem_we3, cpu_gnt3, host_gnt3, cpu_rvalid3, host_rvalid3}, 0);
        chk("t5_rst_dat", {mem_addr3, mem_wdata3, cpu_rdata3}, 0);
        step();
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("t5_norv", cpu_rvalid3, 0);
        end
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h030;
        host_req = 1; host_we = 1; host_addr = 12'h040;
        step();
        chk("t5_tie_cpu", {cpu_gnt3, host_gnt3}, 2'b10);
        idle(6);

        // Back-to-back CPU writes with req held
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h001; cpu_wdata = 16'hA001;
        step();
        chk("t6_g1", cpu_gnt1, 1);
        chk("t6_a1", mem_addr1, 12'h001);
        cpu_addr = 12'h002; cpu_wdata = 16'hA002;
        step();
        chk("t6_gap1", cpu_gnt1, 0);
        step();
        chk("t6_g2", cpu_gnt1, 1);
        chk("t6_a2", mem_addr1, 12'h002);
        cpu_addr = 12'h003; cpu_wdata = 16'hA003;
        step();
        chk("t6_gap2", cpu_gnt1, 0);
        step();
        chk("t6_g3", cpu_gnt1, 1);
        chk("t6_a3", mem_addr1, 12'h003);
        chk("t6_wd3", mem_wdata1, 16'hA003);
        cpu_req = 0;
        step();
        chk("t6_gap3", cpu_gnt1, 0);
        step();
        chk("t6_idle", {cpu_gnt1, busy1}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
